// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one CW-bit delay counter between NREQ requesters.
// Define DLY_TIMER_PRESCALE_EN to advance the counter once every PRESCALE clocks.
module delay_timer_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned CW       = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   dly,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [NREQ-1:0]      done,
  output logic [CW-1:0]        cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   target_q, target_d;
  logic [CW-1:0]   cnt_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic            busy_d;

  logic            tick_c;
  logic            any_c;
  logic [PW-1:0]   win_c;
  logic            owner_req_c;
  logic [CW-1:0]   owner_dly_c;
  int              arb_idx;

`ifdef DLY_TIMER_PRESCALE_EN
  localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;

  assign tick_c = (tcnt_q == TW'(PRESCALE - 1));

  // Tick divider: restarts with each load, wraps at PRESCALE-1 while running
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == S_LOAD) begin
      tcnt_d = '0;
    end else if (state_q == S_RUN) begin
      tcnt_d = tick_c ? '0 : tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign tick_c = 1'b1;

  // PRESCALE has no effect without the divider
  if (PRESCALE == 0) begin : g_prescale_unused
  end
`endif

  // Lowest index at or after the pointer wins; descending scan lets it overwrite
  always_comb begin
    any_c   = 1'b0;
    win_c   = '0;
    arb_idx = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= int'(NREQ)) begin
        arb_idx = arb_idx - int'(NREQ);
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if ((i == arb_idx) && req[i]) begin
          any_c = 1'b1;
          win_c = PW'(i);
        end
      end
    end
  end

  always_comb begin
    owner_req_c = 1'b0;
    owner_dly_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == PW'(i)) begin
        owner_req_c = req[i];
        owner_dly_c = dly[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    target_d = target_q;
    cnt_d    = cnt;
    grant_d  = grant;
    done_d   = '0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (any_c) begin
          owner_d = win_c;
          grant_d = NREQ'(1) << win_c;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        target_d = owner_dly_c;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (!owner_req_c) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (cnt == target_q) begin
          done_d  = grant;
          state_d = S_DONE;
        end else if (tick_c) begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (int'(owner_q) == int'(NREQ) - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + PW'(1);
        end
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      target_q <= '0;
      cnt      <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      target_q <= target_d;
      cnt      <= cnt_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter: vector table of single grants plus
// contention, abort and mid-run reset sequences.
module tb_delay_timer_arbiter;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned CW       = 4;
  localparam int unsigned PRESCALE = 4;
`ifdef DLY_TIMER_PRESCALE_EN
  localparam int TICKS = PRESCALE;
`else
  localparam int TICKS = 1;
`endif

  typedef struct {
    logic [1:0] req;
    logic [3:0] d0;
    logic [3:0] d1;
    int         win;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*CW-1:0]   dly = '0;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [NREQ-1:0]      done;
  logic [CW-1:0]        cnt;

  int tests = 0;
  int fails = 0;
  int n, e, dbl, ndone;
  vec_t vecs[6];

  delay_timer_arbiter #(
    .NREQ(NREQ),
    .CW(CW),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .dly(dly),
    .grant(grant),
    .busy(busy),
    .done(done),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: drive at a negedge, edge 0 samples it, cycle k follows edge k-1
  task automatic run_single(input vec_t v);
    int cyc;
    int d;
    int overlap;
    overlap = 0;
    d = (v.win == 0) ? int'(v.d0) : int'(v.d1);
    @(negedge clk);
    req = v.req;
    dly = {v.d1, v.d0};
    step();
    cyc = 1;
    check("vec_grant", int'(grant), 1 << v.win);
    check("vec_busy", int'(busy), 1);
    while (done == '0 && cyc < 300) begin
      step();
      cyc++;
      if ($countones(grant) > 1) overlap++;
    end
    check("vec_done", int'(done), 1 << v.win);
    check("vec_cycle", cyc, TICKS * d + 3);
    check("vec_cnt", int'(cnt), d);
    @(negedge clk);
    req = '0;
    step();
    check("vec_busy_low", int'(busy), 0);
    check("vec_grant_low", int'(grant), 0);
    check("vec_done_low", int'(done), 0);
    check("vec_overlap", overlap, 0);
  endtask

  initial begin
    vecs[0] = '{req: 2'b01, d0: 4'd3,  d1: 4'd0,  win: 0};
    vecs[1] = '{req: 2'b10, d0: 4'd0,  d1: 4'd0,  win: 1};
    vecs[2] = '{req: 2'b01, d0: 4'd0,  d1: 4'd7,  win: 0};
    vecs[3] = '{req: 2'b10, d0: 4'd2,  d1: 4'd15, win: 1};
    vecs[4] = '{req: 2'b11, d0: 4'd1,  d1: 4'd2,  win: 0};
    vecs[5] = '{req: 2'b11, d0: 4'd5,  d1: 4'd7,  win: 1};

    repeat (3) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cnt", int'(cnt), 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i]);
    end

    // Contention: both held, pointer starts at 0 -> owners 0,1,0,1
    @(negedge clk);
    req = 2'b11;
    dly = {4'd1, 4'd2};
    n = 0;
    dbl = 0;
    for (int t = 0; t < 4; t++) begin
      e = t % 2;
      do begin
        step();
        n++;
        if ($countones(grant) > 1) dbl++;
      end while (grant == '0 && n < 300);
      check("cont_grant", int'(grant), 1 << e);
      while (done == '0 && n < 300) begin
        step();
        n++;
        if ($countones(grant) > 1) dbl++;
      end
      check("cont_done", int'(done), 1 << e);
      step();
      n++;
      check("cont_single_pulse", int'(done), 0);
    end
    @(negedge clk);
    req = '0;
    check("cont_overlap", dbl, 0);
    repeat (3) step();

    // Abort at cnt=2 of 5: no done, pointer stays at 0
    @(negedge clk);
    req = 2'b01;
    dly = {4'd0, 4'd5};
    n = 0;
    step();
    while (cnt != 4'd2 && n < 300) begin
      step();
      n++;
    end
    check("abort_reach", int'(cnt), 2);
    @(negedge clk);
    req = 2'b00;
    step();
    check("abort_busy", int'(busy), 0);
    check("abort_grant", int'(grant), 0);
    check("abort_cnt_hold", int'(cnt), 2);
    ndone = 0;
    repeat (5) begin
      step();
      if (done != '0) ndone++;
    end
    check("abort_no_done", ndone, 0);
    @(negedge clk);
    req = 2'b11;
    step();
    check("abort_ptr_kept", int'(grant), 1);
    @(negedge clk);
    req = 2'b00;
    repeat (4) step();
    check("abort_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    req = 2'b01;
    dly = {4'd0, 4'd9};
    n = 0;
    step();
    while (cnt != 4'd3 && n < 300) begin
      step();
      n++;
    end
    check("mid_reach", int'(cnt), 3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_cnt", int'(cnt), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    ndone = 0;
    repeat (20) begin
      step();
      if (done != '0 || busy) ndone++;
    end
    check("mid_rst_quiet", ndone, 0);

`ifdef DLY_TIMER_PRESCALE_EN
    run_single('{req: 2'b01, d0: 4'd15, d1: 4'd0, win: 0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
